// File: rtl/sample_scatter64.sv
// sample_scatter64: serial-to-parallel frame loader for the 64-point FFT path.
// Samples arrive on a valid/ready handshake and are scattered into a 64-entry
// register bank, in natural or 6-bit bit-reversed order. Once all 64 entries
// are written, the bank is frozen and offered as one frame until frame_ack.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   in_data/in_valid  sample stream in; in_ready decoded from state only
//   out_bus           bank contents, entry i at [i*DATA_LENGTH +: DATA_LENGTH]
//   frame_valid       bank holds a complete frame (also state-decoded)
//   frame_ack         consumer released the frame
//   fill_count        samples accepted in current frame, 0..64

// One bank entry: loads d when its write strobe fires, cleared by reset.
module scatter_entry #(
  parameter int DATA_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [DATA_LENGTH-1:0] d,
  output logic [DATA_LENGTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module sample_scatter64 #(
  parameter int DATA_LENGTH = 8,
  parameter bit BITREV      = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_LENGTH-1:0]    in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [64*DATA_LENGTH-1:0] out_bus,
  output logic                      frame_valid,
  input  logic                      frame_ack,
  output logic [6:0]                fill_count
);
  localparam int ENTRIES = 64;

  typedef enum logic {FILL, FULL} state_t;

  state_t      state, state_nxt;
  logic [5:0]  wr_cnt, wr_cnt_nxt;
  logic [5:0]  idx;
  logic        accept;
  logic [ENTRIES-1:0] we;

  // Write index: wr_cnt itself, or its 6-bit mirror so the FFT sees
  // bit-reversed input order without a separate permutation stage.
  generate
    if (BITREV) begin : g_rev
      for (genvar b = 0; b < 6; b++) begin : g_bit
        assign idx[b] = wr_cnt[5-b];
      end
    end else begin : g_nat
      assign idx = wr_cnt;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FILL;
      wr_cnt <= '0;
    end else begin
      state  <= state_nxt;
      wr_cnt <= wr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wr_cnt_nxt = wr_cnt;
    accept     = 1'b0;
    case (state)
      FILL: begin
        // frame_ack is meaningless here; only samples move the FSM.
        if (in_valid) begin
          accept     = 1'b1;
          wr_cnt_nxt = wr_cnt + 6'd1;   // wraps to 0 on the 64th accept
          if (wr_cnt == 6'd63) state_nxt = FULL;
        end
      end
      FULL: begin
        // Bank frozen; in_valid ignored. Release wins over any sample.
        if (frame_ack) begin
          state_nxt  = FILL;
          wr_cnt_nxt = '0;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Handshake outputs come from the state register only, no input paths.
  assign in_ready    = (state == FILL);
  assign frame_valid = (state == FULL);
  // In FULL wr_cnt has already wrapped to 0, so report the full count.
  assign fill_count  = frame_valid ? 7'd64 : {1'b0, wr_cnt};

  assign we = accept ? (ENTRIES'(1) << idx) : '0;

  generate
    for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
      scatter_entry #(.DATA_LENGTH(DATA_LENGTH)) u_ent (
        .clk (clk),
        .rst (rst),
        .we  (we[i]),
        .d   (in_data),
        .q   (out_bus[i*DATA_LENGTH +: DATA_LENGTH])
      );
    end
  endgenerate
endmodule

// File: tb/tb_sample_scatter64.sv
// Randomized bench for sample_scatter64: one natural-order and one
// bit-reversed instance driven by the same stimulus, each checked every
// cycle against a frame-level model (arrays + sample count).
module tb_sample_scatter64;
  localparam int DW = 8;
  localparam int BW = 64*DW;

  logic          clk = 1'b0;
  logic          rst, in_valid, frame_ack;
  logic [DW-1:0] in_data;
  logic          rdy_n, rdy_r, fv_n, fv_r;
  logic [BW-1:0] bus_n, bus_r;
  logic [6:0]    fc_n, fc_r;

  always #5 clk = ~clk;

  sample_scatter64 #(.DATA_LENGTH(DW), .BITREV(1'b0)) u_nat (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_n), .out_bus(bus_n), .frame_valid(fv_n),
    .frame_ack(frame_ack), .fill_count(fc_n));

  sample_scatter64 #(.DATA_LENGTH(DW), .BITREV(1'b1)) u_rev (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_r), .out_bus(bus_r), .frame_valid(fv_r),
    .frame_ack(frame_ack), .fill_count(fc_r));

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: frame state in plain terms.
  logic [DW-1:0] m_nat [64];
  logic [DW-1:0] m_rev [64];
  int            m_cnt  = 0;     // samples held in current frame, 0..64
  bit            m_full = 0;
  int            fv_rises = 0;
  bit            fv_prev  = 0;

  function automatic int rev6(input int k);
    int r = 0;
    for (int b = 0; b < 6; b++) r += ((k >> b) & 1) << (5 - b);
    return r;
  endfunction

  function automatic logic [BW-1:0] pack(input bit rev_sel);
    logic [BW-1:0] v = '0;
    for (int i = 0; i < 64; i++) v[i*DW +: DW] = rev_sel ? m_rev[i] : m_nat[i];
    return v;
  endfunction

  function automatic logic [DW-1:0] ent(input logic [BW-1:0] bus, input int i);
    return bus[i*DW +: DW];
  endfunction

  // One clock: drive, advance the model, check every output of both DUTs.
  task automatic cycle(input bit r, input bit v, input logic [DW-1:0] d, input bit a);
    rst = r; in_valid = v; in_data = d; frame_ack = a;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 64; i++) begin m_nat[i] = '0; m_rev[i] = '0; end
      m_cnt = 0; m_full = 0;
    end else if (!m_full) begin
      if (v) begin
        m_nat[m_cnt] = d;
        m_rev[rev6(m_cnt)] = d;
        m_cnt++;
        if (m_cnt == 64) m_full = 1;
      end
    end else if (a) begin
      m_full = 0; m_cnt = 0;
    end
    #1;
    chk("nat_ready", BW'(rdy_n), BW'(!m_full));
    chk("nat_fvalid", BW'(fv_n), BW'(m_full));
    chk("nat_fcount", BW'(fc_n), BW'(m_cnt));
    chk("nat_bus", bus_n, pack(1'b0));
    chk("rev_ready", BW'(rdy_r), BW'(!m_full));
    chk("rev_fvalid", BW'(fv_r), BW'(m_full));
    chk("rev_fcount", BW'(fc_r), BW'(m_cnt));
    chk("rev_bus", bus_r, pack(1'b1));
    if (fv_n && !fv_prev) fv_rises++;
    fv_prev = fv_n;
  endtask

  initial begin
    int n;
    logic [BW-1:0] snap;
    rst = 1; in_valid = 0; in_data = '0; frame_ack = 0;
    for (int i = 0; i < 64; i++) begin m_nat[i] = '0; m_rev[i] = '0; end

    // Reset and idle
    cycle(1, 0, 8'h00, 0);
    cycle(1, 0, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);
    chk("rst_ready", BW'(rdy_n), BW'(1));
    chk("rst_fcount", BW'(fc_n), BW'(0));
    chk("rst_bus", bus_n, '0);

    // Back-to-back natural fill 0x00..0x3F; frame_valid after 64th accept
    for (int i = 0; i < 64; i++) begin
      chk("fill_not_full", BW'(fv_n), BW'(0));
      cycle(0, 1, DW'(i), 0);
    end
    chk("full_fvalid", BW'(fv_n), BW'(1));
    chk("full_fcount", BW'(fc_n), BW'(64));
    chk("full_ready", BW'(rdy_n), BW'(0));
    chk("nat_e5", BW'(ent(bus_n, 5)), BW'(5));
    chk("nat_e63", BW'(ent(bus_n, 63)), BW'(63));
    chk("rev_e0", BW'(ent(bus_r, 0)), BW'(0));
    chk("rev_e1", BW'(ent(bus_r, 1)), BW'(32));
    chk("rev_e2", BW'(ent(bus_r, 2)), BW'(16));
    chk("rev_e32", BW'(ent(bus_r, 32)), BW'(1));
    chk("rev_e63", BW'(ent(bus_r, 63)), BW'(63));

    // Back-pressure: 0xAA offered while FULL must not land
    snap = bus_n;
    for (int i = 0; i < 10; i++) cycle(0, 1, 8'hAA, 0);
    chk("frozen_bus", bus_n, snap);
    // Release with in_valid also high: only the release happens
    cycle(0, 1, 8'hAA, 1);
    chk("rel_ready", BW'(rdy_n), BW'(1));
    chk("rel_fcount", BW'(fc_n), BW'(0));
    chk("rel_bus", bus_n, snap);
    cycle(0, 1, 8'h55, 0);
    chk("new_e0", BW'(ent(bus_n, 0)), BW'(8'h55));
    chk("keep_e1", BW'(ent(bus_n, 1)), BW'(1));
    chk("keep_e63", BW'(ent(bus_n, 63)), BW'(63));

    // Finish that frame with random data, then release
    for (int i = 0; i < 63; i++) cycle(0, 1, DW'($urandom), 0);
    cycle(0, 0, 8'h00, 1);

    // Gapped fill of 0..63 with random frame_ack noise in FILL
    n = 0;
    for (int t = 0; t < 2000 && n < 64; t++) begin
      if ($urandom_range(0, 2) != 0) begin
        cycle(0, 1, DW'(n), $urandom_range(0, 1) == 1);
        n++;
      end else begin
        cycle(0, 0, DW'($urandom), $urandom_range(0, 1) == 1);
      end
    end
    chk("gap_done", BW'(n), BW'(64));
    chk("gap_fvalid", BW'(fv_n), BW'(1));
    for (int i = 0; i < 64; i += 9) chk("gap_entry", BW'(ent(bus_n, i)), BW'(i));
    cycle(0, 0, 8'h00, 1);

    // Reset mid-fill with a sample offered in the same cycle
    for (int i = 0; i < 20; i++) cycle(0, 1, DW'($urandom), 0);
    cycle(1, 1, 8'hEE, 0);
    chk("midrst_fcount", BW'(fc_n), BW'(0));
    chk("midrst_bus", bus_n, '0);
    chk("midrst_rbus", bus_r, '0);
    fv_rises = 0;
    for (int i = 0; i < 64; i++) cycle(0, 1, DW'($urandom), 0);
    for (int i = 0; i < 5; i++) cycle(0, $urandom_range(0, 1) == 1, DW'($urandom), 0);
    chk("one_frame", BW'(fv_rises), BW'(1));

    // Random soak: valid, ack and occasional reset
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
            DW'($urandom), $urandom_range(0, 3) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/sample_scatter64.md
# sample_scatter64

Frame loader that accepts a serial stream of DATA_LENGTH-bit samples over a valid/ready handshake and scatters them into a 64-entry register bank. Once all 64 entries are filled, the whole bank is presented in parallel to the 16/64-point FFT datapath as a stable frame. It is the write side of the 64-way sample path; the 64-to-1 read-select mux sits on the other end. An optional bit-reversed write order delivers FFT inputs already permuted.

## Interface
- DATA_LENGTH, 8, sample width in bits
- BITREV, 0, 1 = entry k is written at the 6-bit bit-reversed index of k; 0 = natural order

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_data  in  DATA_LENGTH  sample to write
- in_valid  in  1  in_data is valid this cycle
- in_ready  out  1  block can accept a sample this cycle
- out_bus  out  64*DATA_LENGTH  bank contents; entry i at bits [i*DATA_LENGTH +: DATA_LENGTH]
- frame_valid  out  1  bank holds a complete frame
- frame_ack  in  1  consumer has taken the frame; releases the bank
- fill_count  out  7  samples accepted in the current frame, 0..64

## Operation
- Two states: FILL and FULL. Reset state is FILL.
- An accept occurs when in_valid && in_ready are high at a rising edge.
- FILL:
  - in_ready=1 and frame_valid=0.
  - On accept, write in_data to bank[idx]. idx = wr_cnt when BITREV=0, otherwise bit-reverse of wr_cnt[5:0]. Then increment wr_cnt (6-bit).
  - On the accept with wr_cnt==63: wr_cnt wraps to 0 and the state moves to FULL.
  - frame_ack is ignored.
- FULL:
  - in_ready=0 and frame_valid=1.
  - The bank is frozen; in_valid is ignored and no write occurs.
  - frame_ack=1 moves the state to FILL on the next edge.
- fill_count:
  - FILL: equals wr_cnt (0..63).
  - FULL: reads 64.
  - Returning to FILL resets it to 0.
- The bank is not cleared between frames. Entries keep the previous frame's values until they are overwritten.
- in_ready and frame_valid are decoded from the state register only. They have no combinational path from any input.
- rst asserted in any state, including mid-fill or in FULL, on the next edge:
  - state goes to FILL, wr_cnt to 0, all bank entries to 0.
  - An accept attempted in the same cycle as rst is discarded.
- in_data is stored unmodified. There is no width conversion, sign handling or saturation.

## Timing
- Reset values: in_ready=1, frame_valid=0, fill_count=0, out_bus=0.
- Write latency: a sample accepted at edge N appears on out_bus after edge N.
- Frame latency: 64 accepts on consecutive cycles give frame_valid=1 in the cycle after the 64th accept edge. Minimum fill time is 64 cycles.
- Release:
  - frame_ack high at edge M (in FULL) gives in_ready=1 and frame_valid=0 after M.
  - The earliest next-frame accept is edge M+1.
  - Frame-to-frame throughput is therefore at least 65 cycles.
- frame_ack held high across several cycles in FILL has no effect. frame_ack and in_valid high together in FULL: only the release happens; the sample is not taken.
- Stalls: in_valid gaps during FILL hold wr_cnt and the bank unchanged. There is no timeout.

## Test plan
- Reset/idle: hold rst for 2 cycles, then release → in_ready=1, frame_valid=0, fill_count=0, out_bus all zero.
- Natural fill (BITREV=0): drive samples 0x00..0x3F back-to-back → frame_valid rises the cycle after the 64th accept. Entry i = i, fill_count=64, in_ready=0.
- Back-pressure and release: in FULL, drive in_valid=1 with 0xAA for 10 cycles → bank unchanged. Pulse frame_ack for one cycle → next cycle in_ready=1, fill_count=0. The next sample 0x55 lands in entry 0; entries 1..63 keep their old values.
- Bit-reversed fill (BITREV=1): drive samples 0..63 → entry 1 = 32, entry 2 = 16, entry 32 = 1, entry 63 = 63, entry 0 = 0.
- Gapped input: 64 samples with random in_valid gaps → same bank as the back-to-back fill. fill_count steps by 1 only on accepts.
- Reset mid-operation: assert rst after 20 accepts, with in_valid high in the same cycle → next cycle fill_count=0 and out_bus=0. Then 64 fresh samples produce exactly one frame_valid.
